outstream: RTL and testbench

- Capture sink for one output port of the node array. It accepts values pushed by a node over the write/wready handshake and stores them in a 64-entry buffer.
- It compares each accepted value against an expected list and raises done once `length` values have been accepted.
- It is the downstream counterpart of the stimulus stream source and is used by the test harness to judge a puzzle run.

---
 rtl/outstream.sv | 122 ++++++++++++
 tb/tb_outstream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/outstream.sv
// outstream: capture sink for one node-array output port. Accepts pushed words
// over a write/wready handshake, stores them, checks them against an expected
// list and flags done/mismatch/overflow.
module outstream #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 64,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CW-1:0]    length,
    input  logic [WIDTH-1:0] expected [DEPTH],
    input  logic             write,
    input  logic [WIDTH-1:0] in,
    output logic             wready,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] captured [DEPTH],
    output logic             done,
    output logic             mismatch,
    output logic [CW-1:0]    err_idx,
    output logic             overflow
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mismatch_q, mismatch_d;
    logic [CW-1:0]    err_idx_q, err_idx_d;
    logic             overflow_q, overflow_d;
    logic             cap_en;
    logic [WIDTH-1:0] captured_q [DEPTH];

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            err_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            err_idx_q  <= err_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic; clear overrides everything but leaves the buffer alone
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        err_idx_d  = err_idx_q;
        overflow_d = overflow_q;
        cap_en     = 1'b0;
        if (clear) begin
            state_d    = RUN;
            count_d    = '0;
            mismatch_d = 1'b0;
            err_idx_d  = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (write) begin
                        cap_en = 1'b1;
                        if ((in != expected[count_q]) && !mismatch_q) begin
                            mismatch_d = 1'b1;
                            err_idx_d  = count_q;
                        end
                        count_d = count_q + CW'(1);
                        state_d = ACK;
                    end
                end
                ACK: begin
                    state_d = (count_q == length) ? DONE : RUN;
                end
                DONE: begin
                    if (write) begin
                        overflow_d = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Capture buffer; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                captured_q[i] <= '0;
            end
        end else if (cap_en) begin
            captured_q[count_q] <= in;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        wready   = (state_q == ACK);
        done     = (state_q == DONE);
        count    = count_q;
        mismatch = mismatch_q;
        err_idx  = err_idx_q;
        overflow = overflow_q;
        captured = captured_q;
    end

endmodule

// File: tb/tb_outstream.sv
// tb_outstream: directed stimulus with a scoreboard queue; a monitor pops and
// checks one entry per wready pulse.
module tb_outstream;

    localparam int WIDTH = 11;
    localparam int DEPTH = 64;
    localparam int CW    = 6;

    typedef struct {
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] data;
        logic             mis;
        logic [CW-1:0]    err;
    } sb_t;

    logic             clk;
    logic             rst;
    logic             clear;
    logic [CW-1:0]    length;
    logic [WIDTH-1:0] exp_arr [DEPTH];
    logic             write;
    logic [WIDTH-1:0] din;
    logic             wready;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] cap [DEPTH];
    logic             done;
    logic             mismatch;
    logic [CW-1:0]    err_idx;
    logic             overflow;

    sb_t sb [$];
    int  checks   = 0;
    int  failures = 0;
    int  pulses   = 0;
    int  p0;

    outstream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .length(length),
        .expected(exp_arr), .write(write), .in(din), .wready(wready),
        .count(count), .captured(cap), .done(done), .mismatch(mismatch),
        .err_idx(err_idx), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every wready pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst === 1'b1 && wready === 1'b1) begin
            sb_t e;
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wready: got wready=1 expected no pulse (count=%0d)", count);
            end else begin
                e = sb.pop_front();
                check("mon_count", 32'(count), 32'(e.cnt));
                check("mon_data", 32'(cap[e.cnt - 1]), 32'(e.data));
                check("mon_mismatch", 32'(mismatch), 32'(e.mis));
                check("mon_err_idx", 32'(err_idx), 32'(e.err));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; write = 1'b0; clear = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic set_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = '0;
        exp_arr[0] = a; exp_arr[1] = b; exp_arr[2] = c; exp_arr[3] = d;
    endtask

    // One push on alternate cycles; optionally records the expected response
    task automatic push(input logic [WIDTH-1:0] v, input logic sb_en, input logic [CW-1:0] ecnt,
                        input logic emis, input logic [CW-1:0] eerr);
        sb_t e;
        if (sb_en) begin
            e.cnt = ecnt; e.data = v; e.mis = emis; e.err = eerr;
            sb.push_back(e);
        end
        write = 1'b1; din = v;
        @(posedge clk); #1 write = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; clear = 1'b0; write = 1'b0; din = '0; length = '0;
        set_exp(0, 0, 0, 0);

        // Basic run
        length = 6'd3;
        set_exp(11'd5, 11'h7F9, 11'd999, 0);
        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_err_idx", 32'(err_idx), 0);
        check("rst_overflow", 32'(overflow), 0);
        p0 = pulses;
        push(11'd5,    1, 6'd1, 0, 0);
        check("basic_done_early", 32'(done), 0);
        push(11'h7F9,  1, 6'd2, 0, 0);
        push(11'd999,  1, 6'd3, 0, 0);
        check("basic_done", 32'(done), 1);
        check("basic_pulses", 32'(pulses - p0), 3);
        check("basic_cap0", 32'(cap[0]), 32'd5);
        check("basic_cap1", 32'(cap[1]), 32'h7F9);
        check("basic_cap2", 32'(cap[2]), 32'd999);
        check("basic_mismatch", 32'(mismatch), 0);

        // Mismatch tracking
        length = 6'd4;
        set_exp(11'd1, 11'd2, 11'd3, 11'd4);
        do_reset();
        push(11'd1, 1, 6'd1, 0, 0);
        push(11'd9, 1, 6'd2, 1, 6'd1);
        push(11'd3, 1, 6'd3, 1, 6'd1);
        push(11'd8, 1, 6'd4, 1, 6'd1);
        check("mis_err_idx", 32'(err_idx), 1);
        check("mis_done", 32'(done), 1);

        // Zero length with write held high
        length = '0;
        set_exp(0, 0, 0, 0);
        do_reset();
        write = 1'b1; din = 11'd3;
        p0 = pulses;
        check("zero_done_first", 32'(done), 0);
        @(posedge clk); #1;
        check("zero_done", 32'(done), 1);
        @(posedge clk); #1;
        check("zero_overflow", 32'(overflow), 1);
        check("zero_count", 32'(count), 0);
        write = 1'b0;
        check("zero_pulses", 32'(pulses - p0), 0);

        // Overflow after done
        length = 6'd1;
        set_exp(11'd42, 0, 0, 0);
        do_reset();
        p0 = pulses;
        push(11'd42, 1, 6'd1, 0, 0);
        check("ovf_no_ovf_yet", 32'(overflow), 0);
        push(11'd7, 0, 0, 0, 0);
        check("ovf_cap0", 32'(cap[0]), 32'd42);
        check("ovf_cap1", 32'(cap[1]), 0);
        check("ovf_count", 32'(count), 1);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_pulses", 32'(pulses - p0), 1);

        // Back-to-back with write held high
        length = 6'd2;
        set_exp(11'd10, 11'd20, 0, 0);
        do_reset();
        begin
            sb_t e;
            e.cnt = 6'd1; e.data = 11'd10; e.mis = 0; e.err = 0; sb.push_back(e);
            e.cnt = 6'd2; e.data = 11'd20; e.mis = 0; e.err = 0; sb.push_back(e);
        end
        write = 1'b1; din = 11'd10;
        check("b2b_wr0", 32'(wready), 0);
        @(posedge clk); #1;
        check("b2b_wr1", 32'(wready), 1);
        din = 11'd20;
        @(posedge clk); #1;
        check("b2b_wr2", 32'(wready), 0);
        @(posedge clk); #1;
        check("b2b_wr3", 32'(wready), 1);
        @(posedge clk); #1;
        write = 1'b0;
        check("b2b_done", 32'(done), 1);
        check("b2b_cap0", 32'(cap[0]), 32'd10);
        check("b2b_cap1", 32'(cap[1]), 32'd20);

        // Async reset mid-handshake
        length = 6'd3;
        set_exp(11'd1, 0, 0, 0);
        do_reset();
        write = 1'b1; din = 11'd9;
        @(posedge clk); #1 write = 1'b0;
        check("arst_wready_before", 32'(wready), 1);
        check("arst_mis_before", 32'(mismatch), 1);
        rst = 1'b0;
        #1;
        check("arst_wready", 32'(wready), 0);
        check("arst_mismatch", 32'(mismatch), 0);
        check("arst_count", 32'(count), 0);
        check("arst_cap0", 32'(cap[0]), 0);

        // Clear after a mismatch, then a fresh matching run
        length = 6'd2;
        set_exp(11'd1, 11'd2, 0, 0);
        do_reset();
        push(11'd9, 1, 6'd1, 1, 0);
        check("clr_mis_before", 32'(mismatch), 1);
        length = 6'd1;
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        check("clr_mismatch", 32'(mismatch), 0);
        check("clr_count", 32'(count), 0);
        check("clr_done", 32'(done), 0);
        check("clr_cap0_kept", 32'(cap[0]), 32'd9);
        push(11'd1, 1, 6'd1, 0, 0);
        check("clr_run_done", 32'(done), 1);
        check("clr_run_mismatch", 32'(mismatch), 0);
        check("clr_run_cap0", 32'(cap[0]), 32'd1);

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
